// File: rtl/clk_div_prog_if.sv
// Half-period write port for clk_div_prog: strobe, target channel and new value.
interface clk_div_prog_if #(
  parameter int unsigned CH_W  = 3,
  parameter int unsigned CNT_W = 26
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_half;

  modport master (output wr_en, wr_ch, wr_half);
  modport slave  (input  wr_en, wr_ch, wr_half);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: per-channel 50% square wave plus rising-edge tick,
// half-period reprogrammed through a shadow register that is only applied at a terminal count or sync.
module clk_div_prog #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned DEF_HALF = 4,
  parameter int unsigned CH_W     = 3
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  clk_div_prog_if.slave     wr,
  output logic              mclk_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  active [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;

  assign mclk_out = mclk;

  // Out-of-range channel numbers never match, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr.wr_en && (wr.wr_ch == CH_W'(i));
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        active[i] <= CNT_W'(DEF_HALF);
        shadow[i] <= CNT_W'(DEF_HALF);
      end
      clk_out <= '0;
      tick    <= '0;
      pend    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          active[i]  <= shadow[i];
          pend[i]    <= 1'b0;
        end else if (!en) begin
          tick[i] <= 1'b0;
        end else if (cnt[i] == active[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
          if (pend[i]) begin
            active[i] <= shadow[i];
            pend[i]   <= 1'b0;
          end
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end
        // Placed last so a coincident write keeps pend set; sync/terminal above used the old shadow.
        if (wr_hit[i]) begin
          shadow[i] <= wr.wr_half;
          pend[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: driver pushes model predictions, monitor pops and compares.
module tb_clk_div_prog;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned CNT_W    = 26;
  localparam int unsigned DEF_HALF = 4;
  localparam int unsigned CH_W     = 3;

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tck;
    logic [NUM_CH-1:0] pnd;
  } exp_t;

  logic mclk = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;
  logic sync = 1'b0;
  logic mclk_out;
  logic [NUM_CH-1:0] clk_out, tick, pend;

  clk_div_prog_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  clk_div_prog #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF), .CH_W(CH_W)
  ) dut (
    .mclk(mclk), .rst(rst), .en(en), .sync(sync), .wr(bus),
    .mclk_out(mclk_out), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];

  // Reference model: edges remaining until the next toggle, counted down.
  int rem [NUM_CH];
  int ah  [NUM_CH];
  int sh  [NUM_CH];
  bit lvl [NUM_CH];
  bit tk  [NUM_CH];
  bit pd  [NUM_CH];

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(bit r, bit e, bit s, bit we, int wc, int wh);
    for (int c = 0; c < NUM_CH; c++) begin
      if (!r) begin
        lvl[c] = 0; tk[c] = 0; pd[c] = 0;
        ah[c] = DEF_HALF; sh[c] = DEF_HALF; rem[c] = DEF_HALF + 1;
        continue;
      end
      tk[c] = 0;
      if (s) begin
        lvl[c] = 0; ah[c] = sh[c]; pd[c] = 0; rem[c] = ah[c] + 1;
      end else if (e) begin
        rem[c]--;
        if (rem[c] == 0) begin
          lvl[c] = !lvl[c];
          tk[c]  = lvl[c];
          if (pd[c]) begin ah[c] = sh[c]; pd[c] = 0; end
          rem[c] = ah[c] + 1;
        end
      end
      if (we && wc == c) begin sh[c] = wh; pd[c] = 1; end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    for (int c = 0; c < NUM_CH; c++) begin
      x.clk[c] = lvl[c]; x.tck[c] = tk[c]; x.pnd[c] = pd[c];
    end
    return x;
  endfunction

  // One clock of stimulus, driven just after the falling edge.
  task automatic cyc(input bit r, input bit e, input bit s, input bit we, input int wc, input int wh);
    @(negedge mclk);
    #1;
    rst = r; en = e; sync = s;
    bus.wr_en = we; bus.wr_ch = CH_W'(wc); bus.wr_half = CNT_W'(wh);
    model_step(r, e, s, we, wc, wh);
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 1, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge mclk);
      chk("mclk_out", mclk_out, mclk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("clk_out", clk_out, x.clk);
        chk("tick", tick, x.tck);
        chk("pend", pend, x.pnd);
      end
    end
  end

  initial begin : driver
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_half = '0;
    model_step(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Default divide: rise at edge 5, fall at edge 10.
    cyc(1, 1, 0, 0, 0, 0);
    idle(13);
    // ch1 to H=0 mid-period.
    cyc(1, 1, 0, 1, 1, 0);
    idle(14);
    // en low for 7 cycles.
    idle(2);
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 0, 0, 0);
    idle(8);
    // Pending ch0 H=1, then sync.
    cyc(1, 1, 0, 1, 0, 1);
    idle(1);
    cyc(1, 1, 1, 0, 0, 0);
    idle(12);
    // Out-of-range channel writes.
    cyc(1, 1, 0, 1, NUM_CH, 7);
    cyc(1, 1, 0, 1, 7, 7);
    idle(8);
    // Write H=3 off-terminal, then H=0 exactly on a terminal.
    for (int k = 0; k < 20 && rem[0] != 2; k++) idle(1);
    cyc(1, 1, 0, 1, 0, 3);
    for (int k = 0; k < 20 && rem[0] != 1; k++) idle(1);
    cyc(1, 1, 0, 1, 0, 0);
    idle(16);
    // Write during sync keeps the new value pending.
    cyc(1, 1, 1, 1, 1, 2);
    idle(12);
    // Asynchronous reset while clk_out[0] is high with a write pending.
    cyc(1, 1, 0, 1, 0, 5);
    for (int k = 0; k < 20 && !lvl[0]; k++) idle(1);
    cyc(1, 0, 0, 1, 1, 3);
    @(negedge mclk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_clk_out", clk_out, '0);
    chk("async_tick", tick, '0);
    chk("async_pend", pend, '0);
    model_step(0, 0, 0, 0, 0, 0);
    q.push_back(model_out());
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(12);
    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cyc(1, $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 15, int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
    end
    @(negedge mclk);
    @(negedge mclk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
